// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, reader FSM states and the stereo
// sample bundle used by the audio input reader and its FIFO.
package audio_pkg;

  localparam int SAMPLE_W = 32;
  localparam int LEVEL_W  = 10;
  localparam int MAG_LSB  = SAMPLE_W - 1 - LEVEL_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP
  } rd_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  // |s|, with the most negative value clamped to max positive
  function automatic logic [SAMPLE_W-1:0] mag_of(
    input logic [SAMPLE_W-1:0] s
  );
    logic [SAMPLE_W-1:0] m;
    if (!s[SAMPLE_W-1])
      m = s;
    else if (s == {1'b1, {(SAMPLE_W-1){1'b0}}})
      m = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else
      m = -s;
    return m;
  endfunction

  // bit i set when any magnitude bit at or above 21+i is set
  function automatic logic [LEVEL_W-1:0] therm_of(
    input logic [SAMPLE_W-1:0] m
  );
    logic [LEVEL_W-1:0] t;
    logic [LEVEL_W-1:0] top;
    top = m[SAMPLE_W-2:MAG_LSB];
    for (int i = 0; i < LEVEL_W; i++)
      t[i] = |(top >> i);
    return t;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: DEPTH x 64-bit synchronous FIFO with a
// registered head word, so the head is valid with non-empty.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [2*SAMPLE_W-1:0]   din,
  output logic [2*SAMPLE_W-1:0]   head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [2*SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_nxt;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + 1'b1;

  // storage; only slots already written are ever read
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  // pointers, occupancy and the registered head word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
      if (do_pop && count > (AW+1)'(1))
        head <= mem[rd_nxt];
      else if (do_push && (empty || do_pop))
        head <= din;
    end

endmodule

// File: rtl/audio_in_reader.sv
// audio_in_reader: pops stereo samples from the codec controller
// into a FIFO; optional peak meter built with AUDIO_IN_PEAK_EN.
module audio_in_reader
  import audio_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DECAY_CYCLES = 5_000_000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_left,
  output logic [31:0] out_right,
  output logic [9:0]  level
);

  localparam int AW = $clog2(DEPTH);

  rd_state_t             state;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [AW:0]           count;
  stereo_t               din;
  logic [2*SAMPLE_W-1:0] head;

  assign push      = (state == READ);
  assign pop       = out_valid & out_ready;
  assign out_valid = ~empty;
  assign din.left  = left_channel_audio_in;
  assign din.right = right_channel_audio_in;
  assign out_left  = head[2*SAMPLE_W-1:SAMPLE_W];
  assign out_right = head[SAMPLE_W-1:0];

  audio_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // flag and occupancy views of the FIFO must agree
  a_full: assert property (
    @(posedge CLOCK_50) disable iff (!resetn)
    full == (count == (AW+1)'(DEPTH))
  );

  // one strobe per sample, then a cycle for status to settle
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state         <= IDLE;
      read_audio_in <= 1'b0;
    end else begin
      read_audio_in <= 1'b0;
      unique case (state)
        IDLE:
          if (audio_in_available && !full) begin
            state         <= READ;
            read_audio_in <= 1'b1;
          end
        READ:    state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end

`ifdef AUDIO_IN_PEAK_EN
  localparam int DW =
    (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

  logic [DW-1:0]      decay_cnt;
  logic               decay;
  logic [LEVEL_W-1:0] peak;
  logic [LEVEL_W-1:0] hit;

  assign decay = (decay_cnt == DW'(DECAY_CYCLES - 1));
  assign hit   = push
               ? therm_of(mag_of(left_channel_audio_in))
               : '0;
  assign level = peak;

  // free-running decay period counter
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn)    decay_cnt <= '0;
    else if (decay) decay_cnt <= '0;
    else            decay_cnt <= decay_cnt + 1'b1;

  // peak hold: merge new level on push, halve on decay tick
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn)    peak <= '0;
    else if (decay) peak <= (peak >> 1) | hit;
    else            peak <= peak | hit;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_audio_in_reader.sv
// tb_audio_in_reader: controller model + scoreboard for the
// audio input reader; meter checks follow AUDIO_IN_PEAK_EN.
module tb_audio_in_reader;

  localparam int DEPTH = 4;
  localparam int DECAY = 200;

`ifdef AUDIO_IN_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        avail = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] lin = '0;
  logic [31:0] rin = '0;
  logic        rd;
  logic        ov;
  logic [31:0] ol;
  logic [31:0] orr;
  logic [9:0]  level;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int reads_seen = 0;
  int reads_done = 0;
  logic last_rd = 1'b0;

  logic [63:0] ctrl_q[$];
  logic [63:0] exp_q[$];
  int          read_cyc[$];

  audio_in_reader #(
    .DEPTH        (DEPTH),
    .DECAY_CYCLES (DECAY)
  ) dut (
    .CLOCK_50               (clk),
    .resetn                 (rst_n),
    .audio_in_available     (avail),
    .left_channel_audio_in  (lin),
    .right_channel_audio_in (rin),
    .read_audio_in          (rd),
    .out_valid              (ov),
    .out_ready              (rdy),
    .out_left               (ol),
    .out_right              (orr),
    .level                  (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // peak level of one sample from its magnitude
  function automatic logic [9:0] lvl_of(input logic [31:0] l);
    longint m;
    int idx;
    m = longint'($signed(l));
    if (m < 0) m = -m;
    if (m > 64'sd2147483647) m = 64'sd2147483647;
    idx = -1;
    for (int i = 0; i < 10; i++)
      if (m >= (longint'(1) << (21 + i))) idx = i;
    if (idx < 0) return 10'h0;
    return 10'((1 << (idx + 1)) - 1);
  endfunction

  function automatic logic [9:0] meter(input logic [9:0] v);
    return PEAK_EN ? v : 10'h0;
  endfunction

  // controller model: retire strobed samples, present the next
  always @(posedge clk) begin
    #2;
    while (reads_done < reads_seen) begin
      if (ctrl_q.size() > 0) ctrl_q.delete(0);
      reads_done++;
    end
    avail = (ctrl_q.size() > 0);
    {lin, rin} = avail ? ctrl_q[0] : 64'h0;
  end

  // monitor: record strobes, compare popped heads
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd) begin
        chk("strobe_width", 64'(last_rd), 64'(0));
        if (ctrl_q.size() == 0) begin
          total++;
          $display("FAIL spurious_read: got strobe want none");
        end else begin
          exp_q.push_back(ctrl_q[0]);
        end
        reads_seen++;
        read_cyc.push_back(cyc);
      end
      if (ov && rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_out: got %h want none", {ol, orr});
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("out_left", 64'(ol), 64'(e[63:32]));
          chk("out_right", 64'(orr), 64'(e[31:0]));
        end
      end
      last_rd = rd;
    end else begin
      last_rd = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy = 1'b0;
    ctrl_q.delete();
    exp_q.delete();
    reads_done = reads_seen;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    rdy = 1'b1;
    while ((ctrl_q.size() != 0 || exp_q.size() != 0 || ov)
           && n < bound) begin
      tick();
      n++;
    end
    total++;
    if (n >= bound)
      $display("FAIL %s: got %0d left want 0", name,
               ctrl_q.size() + exp_q.size());
    else
      passed++;
  endtask

  task automatic meter_one(input string name,
                           input logic [31:0] l);
    do_reset();
    rdy = 1'b1;
    ctrl_q.push_back({l, $urandom});
    tick(6);
    chk(name, 64'(level), 64'(meter(lvl_of(l))));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int n;
    logic [9:0]  acc;
    logic [9:0]  prev;
    logic [31:0] l;

    tick(3);
    chk("rst_read", 64'(rd), 64'(0));
    chk("rst_valid", 64'(ov), 64'(0));
    chk("rst_left", 64'(ol), 64'(0));
    chk("rst_right", 64'(orr), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    rst_n = 1'b1;
    tick();

    // single sample with exact strobe/valid timing
    ctrl_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
    @(negedge clk) chk("pre_read", 64'(rd), 64'(0));
    @(negedge clk) chk("read_k1", 64'(rd), 64'(1));
    @(negedge clk) chk("valid_k2", 64'(ov), 64'(1));
    chk("left_k2", 64'(ol), 64'h0000_1234);
    chk("right_k2", 64'(orr), 64'hFFFF_FFFF);
    tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    @(negedge clk) chk("valid_after_pop", 64'(ov), 64'(0));

    // backpressure: four reads fill the FIFO, then stop
    tick();
    r0 = reads_seen;
    read_cyc.delete();
    repeat (6) ctrl_q.push_back({$urandom, $urandom});
    tick(25);
    chk("bp_reads", 64'(reads_seen - r0), 64'(4));
    for (int i = 1; i < read_cyc.size(); i++)
      chk("bp_spacing", 64'(read_cyc[i] - read_cyc[i-1]), 64'(3));
    r0 = reads_seen;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick(10);
    chk("bp_one_more", 64'(reads_seen - r0), 64'(1));

    // full FIFO with continuous ready: push and pop together
    r0 = reads_seen;
    repeat (20) ctrl_q.push_back({$urandom, $urandom});
    drain("stream_drain", 300);
    chk("stream_reads", 64'(reads_seen - r0), 64'(21));

    // random arrivals and random ready
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        ctrl_q.push_back({$urandom, $urandom});
      rdy = 1'($urandom_range(0, 1));
      tick();
    end
    drain("random_drain", 600);

    // meter: single-sample levels
    meter_one("lvl_4000", 32'h4000_0000);
    meter_one("lvl_8000", 32'h8000_0000);
    meter_one("lvl_0020", 32'h0020_0000);
    meter_one("lvl_001f", 32'h001F_FFFF);
    meter_one("lvl_neg21", 32'hFFE0_0000);
    meter_one("lvl_0300", 32'h0300_0000);

    // meter: peak accumulates across pushes
    do_reset();
    rdy = 1'b1;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      l = $urandom >> $urandom_range(1, 12);
      if ($urandom_range(0, 1) == 1) l = -l;
      ctrl_q.push_back({l, $urandom});
      tick(6);
      acc = acc | lvl_of(l);
      chk("lvl_accum", 64'(level), 64'(meter(acc)));
    end

    // meter: decay halves the peak once per period
    meter_one("lvl_pre_decay", 32'h4000_0000);
    prev = level;
    n = 0;
    while (level == prev && n < DECAY + 10) begin
      @(negedge clk);
      n++;
    end
    chk("decay1", 64'(level), 64'(meter(10'h1FF)));
    prev = level;
    n = 0;
    while (level == prev && n < DECAY + 10) begin
      @(negedge clk);
      n++;
    end
    chk("decay2", 64'(level), 64'(meter(10'h0FF)));
    chk("decay_period", 64'(n),
        64'(PEAK_EN ? DECAY : DECAY + 10));

    // reset asserted during the read strobe
    do_reset();
    ctrl_q.push_back({32'h4000_0000, 32'h5555_AAAA});
    tick(6);
    ctrl_q.push_back({32'h1111_2222, 32'h3333_4444});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd && n < 10);
    chk("rst_strobe_seen", 64'(rd), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read", 64'(rd), 64'(0));
    chk("mid_rst_valid", 64'(ov), 64'(0));
    chk("mid_rst_left", 64'(ol), 64'(0));
    chk("mid_rst_right", 64'(orr), 64'(0));
    chk("mid_rst_level", 64'(level), 64'(0));
    ctrl_q.delete();
    exp_q.delete();
    reads_done = reads_seen;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_empty", 64'(ov), 64'(0));
    ctrl_q.push_back({32'h0BAD_F00D, 32'h1234_5678});
    @(negedge clk) chk("post_rst_pre", 64'(rd), 64'(0));
    @(negedge clk) chk("post_rst_read", 64'(rd), 64'(1));
    @(negedge clk) chk("post_rst_valid", 64'(ov), 64'(1));
    chk("post_rst_left", 64'(ol), 64'h0BAD_F00D);
    drain("post_rst_drain", 50);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/audio_in_reader.md
# audio_in_reader

Reader side of the audio-codec input handshake: waits for the codec controller to report a captured stereo sample, pulses `read_audio_in`, and buffers left/right samples in a small FIFO with a valid/ready interface. Downstream mixing and record logic drain that FIFO. It also derives a peak-hold level meter from the left channel for the 10 LEDR outputs. It sits between `Audio_Controller` (input side) and the piano mixer/record path.

## Interface

- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `DECAY_CYCLES`, 5_000_000, clocks between peak-meter decay steps (0.1 s at 50 MHz)
- `CLOCK_50`  in  1  system clock; all logic on rising edge
- `resetn`  in  1  reset, asynchronous assert, active-low
- `audio_in_available`  in  1  controller holds ≥1 unread sample
- `left_channel_audio_in`  in  32  signed left sample, valid while available
- `right_channel_audio_in`  in  32  signed right sample, valid while available
- `read_audio_in`  out  1  one-cycle pop strobe to controller
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head entry when valid & ready
- `out_left` / `out_right`  out  32  FIFO head samples
- `level`  out  10  thermometer peak meter (bit 0 = quietest)

## Operation

- FSM `IDLE`, `READ`, `GAP`:
  - `IDLE` → `READ` when `audio_in_available` & FIFO count < DEPTH; otherwise stay.
  - `READ`: `read_audio_in`=1 (registered, exactly one cycle); push {left,right} sampled this cycle; → `GAP`.
  - `GAP`: ignore `audio_in_available` (controller status updates one cycle late); → `IDLE`.
- FIFO full: no read issued; samples back up in the controller. No drop logic in this block.
- Pop when `out_valid & out_ready`. Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Level meter (see Configuration):
  - mag = |left|, 32-bit; -2^31 saturates to 2^31-1.
  - new = thermometer of the highest set bit among mag[30:21]; bit i set for all i ≤ that index; all-zero if mag[30:21]=0.
  - On push: peak ← peak | new.
  - Decay counter reaches DECAY_CYCLES-1: peak ← peak >> 1, counter → 0.
  - Push and decay in the same cycle: peak ← (peak >> 1) | new.
  - `level` = peak.
- Reset (any time, including mid-`READ`): FSM `IDLE`, FIFO emptied, pointers/count 0, decay counter 0, peak 0. All outputs 0: `read_audio_in`, `out_valid`, `out_left`, `out_right`, `level`.

## Timing

- `audio_in_available` seen high at edge k in `IDLE` → `read_audio_in` high in cycle k+1 → entry written at edge k+2 → `out_valid` high from cycle k+2.
- Maximum rate: one read per 3 cycles (ample for 48 kHz).
- `out_left`/`out_right` are registered FIFO head. Valid the same cycle `out_valid` is high; they update the cycle after a pop.
- `level` updates the cycle after a push or decay event.

## Configuration

- `AUDIO_IN_PEAK_EN` defined: meter, decay counter and peak register are built.
- Undefined: none of that logic exists. `level` is tied to 10'b0. FIFO and handshake are unchanged.

## Structure

- `audio_pkg`:
  - `SAMPLE_W`=32, `LEVEL_W`=10
  - FSM state enum `rd_state_t`
  - stereo sample struct {left,right}
- Sub-module `audio_sample_fifo`: parameterised DEPTH×64-bit synchronous FIFO with push/pop/count/full/empty. Instantiated once. FSM and meter stay in `audio_in_reader`.

## Test plan

- Single sample: available high for 1 cycle with L=0x0000_1234, R=0xFFFF_FFFF. Expect `read_audio_in` pulse at k+1, `out_valid` at k+2, `out_left`=0x0000_1234, `out_right`=0xFFFF_FFFF. Pop with ready → `out_valid` 0.
- Backpressure: `out_ready`=0, available held high. Expect exactly 4 read pulses spaced 3 cycles apart, then none. Raise ready for 1 cycle → one more read follows.
- Simultaneous push/pop at count=4 with ready=1 continuously. Expect count stays ≤4, samples emerge in order, no lost or duplicated values across pointer wrap.
- Meter: L=0x4000_0000 → `level`=10'h3FF. L=0x8000_0000 (saturate) → 10'h3FF. L=0x0020_0000 → 10'h001. After one decay period with no push, 10'h3FF → 10'h1FF.
- Reset mid-`READ`: assert `resetn`=0 during the strobe cycle. All outputs 0 immediately. After release, FIFO empty and next available produces a normal read 1 cycle later.
- Macro off: same stimulus as the meter test. `level` stays 0; FIFO results identical.
